pic_sel_scheduler: RTL

PIC_SEL_SCHEDULER -- requirements
Module: pic_sel_scheduler

---
 rtl/pic_sel_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pic_sel_scheduler.sv
// Picture-select scheduler: picks the picture shown by the VGA block.
// Alarm flashing has the highest priority, then user requests, then the hold timeout.
// sel and state change only at frame boundaries, during vertical back porch.
module pic_sel_scheduler #(
  parameter int unsigned FLASH_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES  = 300,
  parameter logic [1:0]  DEFAULT_PIC  = 2'd0
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       vs_in,
  input  logic       alarm_req,
  input  logic       user_req,
  input  logic [1:0] user_sel,
  output logic [1:0] sel,
  output logic       frame_tick,
  output logic       user_ack,
  output logic       user_err,
  output logic       alarm_active,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  // Index 3 does not exist in the picture store, so an idle picture of 3 falls back to 0.
  localparam logic [1:0] IDLE_SEL = (DEFAULT_PIC == 2'd3) ? 2'd0 : DEFAULT_PIC;
  localparam logic [1:0] SEL_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_USER    = 2'b01,
    ST_ALARM_A = 2'b10,
    ST_ALARM_B = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_d, err_d;
  logic             vs_q;

  // vs_in rising-edge detector producing the one-cycle frame_tick.
  // vs_q resets high, so a tick needs vs_in to be seen low and then high after reset.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vs_in;
      frame_tick <= vs_in & ~vs_q;
    end
  end

  // State, picture select, frame counter and the handshake pulses.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sel          <= IDLE_SEL;
      cnt_q        <= '0;
      user_ack     <= 1'b0;
      user_err     <= 1'b0;
      alarm_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel          <= sel_d;
      cnt_q        <= cnt_d;
      user_ack     <= ack_d;
      user_err     <= err_d;
      alarm_active <= state_d[1];
    end
  end

  // Next-state logic; everything holds unless this cycle carries a frame_tick.
  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_USER: begin
          if (alarm_req) begin
            state_d = ST_ALARM_A;
            sel_d   = 2'd1;
            cnt_d   = '0;
          end else if (user_req) begin
            if (user_sel != SEL_INVALID) begin
              state_d = ST_USER;
              sel_d   = user_sel;
              cnt_d   = '0;
              ack_d   = 1'b1;
            end else begin
              err_d   = 1'b1;
            end
          end else if (state_q == ST_USER) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = ST_IDLE;
              sel_d   = IDLE_SEL;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else begin
            sel_d   = IDLE_SEL;
            cnt_d   = '0;
          end
        end
        ST_ALARM_A, ST_ALARM_B: begin
          // Pending user requests stay unserved while the alarm rings.
          if (!alarm_req) begin
            state_d = ST_IDLE;
            sel_d   = IDLE_SEL;
            cnt_d   = '0;
          end else if (cnt_q == FLASH_LAST) begin
            state_d = (state_q == ST_ALARM_A) ? ST_ALARM_B : ST_ALARM_A;
            sel_d   = (state_q == ST_ALARM_A) ? 2'd2 : 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          sel_d   = IDLE_SEL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule
